// File: rtl/perf_counter_unit.sv
// Performance counter block: NUM_CH event counters plus a free-running cycle
// counter, gated by an IDLE/RUN/FROZEN state machine, with a one-cycle read port.
module perf_counter_unit #(
    parameter int NUM_CH   = 6,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = 3,
    parameter int SAT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              halt,
    input  logic [NUM_CH-1:0] evt,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_err,
    output logic [NUM_CH:0]   ovf,
    output logic              halted
);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt     [NUM_CH+1];
    logic [CNT_W-1:0]   cnt_nxt [NUM_CH+1];
    logic [NUM_CH:0]    ovf_q;
    logic [NUM_CH:0]    ovf_nxt;
    logic [NUM_CH:0]    hit;
    logic [CNT_W:0]     bumped;
    logic               vld_p1;
    logic [SEL_W-1:0]   sel_p1;

    // Returns {overflow, next value}; all-ones either wraps to zero or sticks.
    function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
        if (&v) begin
            if (SAT_MODE != 0) bump = {1'b1, v};
            else               bump = {1'b1, {CNT_W{1'b0}}};
        end else begin
            bump = {1'b0, v + CNT_W'(1)};
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // clr wins over a same-cycle en or halt; it only moves FROZEN back to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && !clr)   state_nxt = RUN;
            RUN:     if (halt && !clr) state_nxt = FROZEN;
            FROZEN:  if (clr)          state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Top bit of hit is the cycle counter, which counts every RUN cycle.
    always_comb begin
        hit     = {1'b1, evt};
        ovf_nxt = ovf_q;
        bumped  = '0;
        for (int i = 0; i <= NUM_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (state == RUN && hit[i]) begin
                bumped     = bump(cnt[i]);
                cnt_nxt[i] = bumped[CNT_W-1:0];
                ovf_nxt[i] = ovf_q[i] | bumped[CNT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_CH; i++) cnt[i] <= '0;
            ovf_q <= '0;
        end else if (clr) begin
            for (int i = 0; i <= NUM_CH; i++) cnt[i] <= '0;
            ovf_q <= '0;
        end else begin
            for (int i = 0; i <= NUM_CH; i++) cnt[i] <= cnt_nxt[i];
            ovf_q <= ovf_nxt;
        end
    end

    // Read stage p1: the select is registered and the counter array, already
    // holding the post-update values, is muxed combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            sel_p1 <= '0;
        end else begin
            vld_p1 <= rd_req;
            sel_p1 <= rd_sel;
        end
    end

    always_comb begin
        rd_data = '0;
        if (vld_p1) begin
            for (int i = 0; i <= NUM_CH; i++) begin
                if (sel_p1 == SEL_W'(i)) rd_data = cnt[i];
            end
        end
    end

    assign rd_valid = vld_p1;
    assign rd_err   = vld_p1 && (sel_p1 > SEL_W'(NUM_CH));
    assign ovf      = ovf_q;
    assign halted   = (state == FROZEN);

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: three instances (16-bit wrap, 8-bit wrap,
// 8-bit saturate) share stimulus and are compared with an arithmetic model.
module tb_perf_counter_unit;

    logic       clk;
    logic       rst_n;
    logic       en, clr, halt, rq;
    logic [5:0] evt;
    logic [2:0] sel;

    logic        rv [3];
    logic        re [3];
    logic        hl [3];
    logic [6:0]  ov [3];
    logic [15:0] rd_a;
    logic [7:0]  rd_b;
    logic [7:0]  rd_c;

    perf_counter_unit #(.NUM_CH(6), .CNT_W(16), .SEL_W(3), .SAT_MODE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rq), .rd_sel(sel), .rd_valid(rv[0]), .rd_data(rd_a),
        .rd_err(re[0]), .ovf(ov[0]), .halted(hl[0]));

    perf_counter_unit #(.NUM_CH(6), .CNT_W(8), .SEL_W(3), .SAT_MODE(0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rq), .rd_sel(sel), .rd_valid(rv[1]), .rd_data(rd_b),
        .rd_err(re[1]), .ovf(ov[1]), .halted(hl[1]));

    perf_counter_unit #(.NUM_CH(6), .CNT_W(8), .SEL_W(3), .SAT_MODE(1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .halt(halt), .evt(evt),
        .rd_req(rq), .rd_sel(sel), .rd_valid(rv[2]), .rd_data(rd_c),
        .rd_err(re[2]), .ovf(ov[2]), .halted(hl[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as 0=IDLE 1=RUN 2=FROZEN, counters as integers.
    int          mst;
    int unsigned mcnt [3][7];
    logic [6:0]  movf [3];
    int          mw   [3] = '{16, 8, 8};
    int          msat [3] = '{0, 0, 1};
    logic        exp_rv, exp_re;
    int unsigned exp_rd [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_of(input int k);
        if (k == 0)      return {16'd0, rd_a};
        else if (k == 1) return {24'd0, rd_b};
        else             return {24'd0, rd_c};
    endfunction

    task automatic model_reset();
        mst = 0;
        for (int k = 0; k < 3; k++) begin
            movf[k] = '0;
            exp_rd[k] = 0;
            for (int c = 0; c < 7; c++) mcnt[k][c] = 0;
        end
        exp_rv = 0;
        exp_re = 0;
    endtask

    task automatic model_step();
        int unsigned maxv;
        if (clr) begin
            for (int k = 0; k < 3; k++) begin
                movf[k] = '0;
                for (int c = 0; c < 7; c++) mcnt[k][c] = 0;
            end
            if (mst == 2) mst = 0;
        end else if (mst == 1) begin
            for (int k = 0; k < 3; k++) begin
                maxv = (32'd1 << mw[k]) - 1;
                for (int c = 0; c < 7; c++) begin
                    if (c == 6 || evt[c]) begin
                        if (mcnt[k][c] == maxv) begin
                            movf[k][c] = 1'b1;
                            mcnt[k][c] = (msat[k] != 0) ? maxv : 0;
                        end else begin
                            mcnt[k][c] = mcnt[k][c] + 1;
                        end
                    end
                end
            end
            if (halt) mst = 2;
        end else if (mst == 0 && en) begin
            mst = 1;
        end
        exp_rv = rq;
        exp_re = rq && (sel > 3'd6);
        for (int k = 0; k < 3; k++)
            exp_rd[k] = (rq && sel <= 3'd6) ? mcnt[k][sel] : 0;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd_valid[%0d]", k), {31'd0, rv[k]}, {31'd0, exp_rv});
            chk($sformatf("rd_data[%0d]", k), data_of(k), exp_rd[k]);
            chk($sformatf("rd_err[%0d]", k), {31'd0, re[k]}, {31'd0, exp_re});
            chk($sformatf("ovf[%0d]", k), {25'd0, ov[k]}, {25'd0, movf[k]});
            chk($sformatf("halted[%0d]", k), {31'd0, hl[k]}, (mst == 2) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic drive(input logic e, input logic c, input logic h,
                         input logic [5:0] v, input logic r, input logic [2:0] s);
        en = e; clr = c; halt = h; evt = v; rq = r; sel = s;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 6'h00, 0, 3'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        en, clr, halt;
        logic [5:0]  evt;
        logic        rq;
        logic [2:0]  sel;
        logic        ev;
        logic [15:0] ed;
        logic        ee;
        logic        eh;
    } vec_t;

    function automatic vec_t mk(input logic e, input logic c, input logic h,
                                input logic [5:0] v, input logic r, input logic [2:0] s,
                                input logic ev, input logic [15:0] ed,
                                input logic ee, input logic eh);
        vec_t t;
        t.en = e; t.clr = c; t.halt = h; t.evt = v; t.rq = r; t.sel = s;
        t.ev = ev; t.ed = ed; t.ee = ee; t.eh = eh;
        return t;
    endfunction

    vec_t tbl [24];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 6'h00, 0, 3'd0);

        // Count 10 events then halt; probe reads while frozen, clear, restart.
        tbl[0] = mk(1, 0, 0, 6'h01, 1, 3'd0, 1, 16'd0, 0, 0);
        for (int i = 1; i <= 10; i++)
            tbl[i] = mk(0, 0, (i == 10), 6'h01, 0, 3'd0, 0, 16'd0, 0, (i == 10));
        tbl[11] = mk(0, 0, 0, 6'h00, 1, 3'd0, 1, 16'd10, 0, 1);
        tbl[12] = mk(0, 0, 0, 6'h00, 1, 3'd6, 1, 16'd10, 0, 1);
        tbl[13] = mk(0, 0, 0, 6'h00, 1, 3'd7, 1, 16'd0, 1, 1);
        for (int i = 14; i <= 18; i++)
            tbl[i] = mk(0, 0, 0, (i % 2 != 0) ? 6'h3F : 6'h15, 1, 3'd0, 1, 16'd10, 0, 1);
        tbl[19] = mk(0, 1, 0, 6'h00, 0, 3'd0, 0, 16'd0, 0, 0);
        tbl[20] = mk(0, 0, 0, 6'h00, 1, 3'd0, 1, 16'd0, 0, 0);
        tbl[21] = mk(1, 0, 0, 6'h00, 0, 3'd0, 0, 16'd0, 0, 0);
        tbl[22] = mk(0, 0, 0, 6'h02, 1, 3'd1, 1, 16'd1, 0, 0);
        tbl[23] = mk(0, 0, 0, 6'h00, 1, 3'd6, 1, 16'd2, 0, 0);

        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].en, tbl[i].clr, tbl[i].halt, tbl[i].evt, tbl[i].rq, tbl[i].sel);
            cycle();
            chk($sformatf("vec%0d rd_valid", i), {31'd0, rv[0]}, {31'd0, tbl[i].ev});
            chk($sformatf("vec%0d rd_data", i), {16'd0, rd_a}, {16'd0, tbl[i].ed});
            chk($sformatf("vec%0d rd_err", i), {31'd0, re[0]}, {31'd0, tbl[i].ee});
            chk($sformatf("vec%0d halted", i), {31'd0, hl[0]}, {31'd0, tbl[i].eh});
        end

        // clr together with all events while running: everything reads zero, still RUN.
        drive(0, 1, 0, 6'h3F, 0, 3'd0);
        cycle();
        chk("clr_evt ovf", {25'd0, ov[0]}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 6'h00, 1, 3'(i));
            cycle();
            chk($sformatf("clr_evt ch%0d", i), {16'd0, rd_a}, 32'd0);
            chk($sformatf("clr_evt halted%0d", i), {31'd0, hl[0]}, 32'd0);
        end
        drive(0, 0, 0, 6'h00, 1, 3'd6);
        cycle();
        chk("clr_evt cycles", {16'd0, rd_a}, 32'd7);

        // 257 events on channel 2: 16-bit counts through, 8-bit wraps or saturates.
        do_reset();
        drive(1, 0, 0, 6'h00, 0, 3'd0);
        cycle();
        for (int i = 0; i < 257; i++) begin
            drive(0, 0, 0, 6'h04, 0, 3'd0);
            cycle();
        end
        drive(0, 0, 0, 6'h00, 1, 3'd2);
        cycle();
        chk("ovf257 wide", {16'd0, rd_a}, 32'd257);
        chk("ovf257 wrap", {24'd0, rd_b}, 32'd1);
        chk("ovf257 sat", {24'd0, rd_c}, 32'd255);
        chk("ovf257 wide ovf2", {31'd0, ov[0][2]}, 32'd0);
        chk("ovf257 wrap ovf2", {31'd0, ov[1][2]}, 32'd1);
        chk("ovf257 sat ovf2", {31'd0, ov[2][2]}, 32'd1);

        // Reset arriving right after a read request cancels everything.
        drive(0, 0, 0, 6'h01, 1, 3'd0);
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 6'h00, 0, 3'd0);
            cycle();
            chk($sformatf("rst_abort valid%0d", i), {31'd0, rv[0]}, 32'd0);
            chk($sformatf("rst_abort data%0d", i), {16'd0, rd_a}, 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 29) == 0),
                  6'($urandom),
                  ($urandom_range(0, 1) == 1),
                  3'($urandom_range(0, 7)));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_unit.md
PERF_COUNTER_UNIT -- requirements
Module: perf_counter_unit

Interface
REQ-001 Parameter NUM_CH, default 6, number of event channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of every counter (8..32).
REQ-003 Parameter SEL_W, default 3, read-select width; SHALL satisfy 2**SEL_W >= NUM_CH+1.
REQ-004 Parameter SAT_MODE, default 0, overflow mode: 0 = wrap, 1 = saturate.
REQ-005 Port clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port rst_n  in  1  asynchronous, active-low reset.
REQ-007 Port en  in  1  start request: arms counting from IDLE.
REQ-008 Port clr  in  1  synchronous clear of all counters and overflow flags.
REQ-009 Port halt  in  1  processor-halt indication: freezes counting.
REQ-010 Port evt  in  NUM_CH  per-channel event strobes, one count per cycle per asserted bit.
REQ-011 Port rd_req  in  1  read request, single-cycle pulse.
REQ-012 Port rd_sel  in  SEL_W  read index: 0..NUM_CH-1 selects an event channel, NUM_CH selects the cycle counter.
REQ-013 Port rd_valid  out  1  read data valid, one-cycle pulse.
REQ-014 Port rd_data  out  CNT_W  read data.
REQ-015 Port rd_err  out  1  out-of-range select, valid alongside rd_valid.
REQ-016 Port ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH belongs to the cycle counter.
REQ-017 Port halted  out  1  high while in FROZEN.

Function
REQ-018 The state machine SHALL have three states: IDLE, RUN and FROZEN.
REQ-019 Transitions: IDLE->RUN when en=1; RUN->FROZEN when halt=1 and clr=0; FROZEN->IDLE when clr=1. All other input combinations hold the current state.
REQ-020 In RUN, the cycle counter SHALL increment every cycle, and channel i SHALL increment when evt[i]=1, including in the cycle halt is sampled.
REQ-021 In IDLE and FROZEN, all counters SHALL hold their values; evt is ignored.
REQ-022 clr=1 in any state SHALL zero all counters and ovf in the next cycle, and SHALL take priority over same-cycle events and halt. The state is unchanged except FROZEN->IDLE.
REQ-023 Wrap mode: a counter at all-ones that receives an increment SHALL become 0 and set its ovf bit.
REQ-024 Saturate mode: a counter at all-ones SHALL stay at all-ones and set its ovf bit on any further increment.
REQ-025 ovf bits SHALL remain set until clr or reset.
REQ-026 A read SHALL have a latency of 1 cycle: rd_req in cycle N gives rd_valid=1 in N+1, with rd_data equal to the counter value after the cycle-N update.
REQ-027 rd_sel > NUM_CH SHALL return rd_data=0 and rd_err=1 alongside rd_valid.
REQ-028 rd_data and rd_err SHALL be 0 whenever rd_valid=0.
REQ-029 Back-to-back rd_req in consecutive cycles SHALL each produce one rd_valid, in order.
REQ-030 halted SHALL equal 1 exactly while the state is FROZEN.

Reset
REQ-031 When rst_n=0, asynchronously: state=IDLE; all counters=0; ovf=0; rd_valid=0; rd_data=0; rd_err=0; halted=0.
REQ-032 Reset asserted mid-RUN or mid-read SHALL abort the operation; no rd_valid SHALL appear after rst_n is released.
REQ-033 The first count SHALL occur no earlier than the first rising edge after en is sampled following rst_n release.

Verification
REQ-034 Reset, en=1, evt[0]=1 for 10 cycles, halt on cycle 10, rd_sel=0 -> rd_data=10; rd_sel=NUM_CH -> cycle count 10; halted=1.
REQ-035 CNT_W=8, SAT_MODE=0, 257 events on channel 2 -> read 1, ovf[2]=1; same with SAT_MODE=1 -> read 255, ovf[2]=1.
REQ-036 In RUN, clr and evt=all-ones in the same cycle -> every channel reads 0 and ovf=0 afterwards; state stays RUN.
REQ-037 Issue rd_req with rd_sel=7 (NUM_CH=6) -> rd_valid=1, rd_err=1, rd_data=0 one cycle later.
REQ-038 In FROZEN, toggle evt for 5 cycles -> counts unchanged; clr -> state IDLE, counts 0; en -> counting resumes.
REQ-039 Assert rst_n=0 one cycle after rd_req -> no rd_valid observed; all outputs 0.
